lcd_view_ctrl: RTL

//  Parametrised image-viewer controller. Loads an IMG_W x IMG_H frame into an internal buffer and

---
 rtl/lcd_view_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_view_ctrl.sv
// lcd_view_ctrl: image-viewer controller. Buffers one IMG_W x IMG_H frame,
// then streams a WIN_W x WIN_H view (subsampled fit or 1:1 zoom window)
// in one of four 90-degree orientations after every accepted command.
module lcd_view_ctrl #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN_W  = 4,
  parameter int WIN_H  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              output_valid,
  output logic              busy
);

  localparam int N    = IMG_W * IMG_H;
  localparam int AW   = (N > 1) ? $clog2(N) : 1;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WMAX = (WIN_W > WIN_H) ? WIN_W : WIN_H;
  localparam int CW   = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam int SX   = IMG_W / WIN_W;
  localparam int SY   = IMG_H / WIN_H;

  localparam logic [XW-1:0] X0   = XW'((IMG_W - WIN_W) / 2);
  localparam logic [YW-1:0] Y0   = YW'((IMG_H - WIN_H) / 2);
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - WIN_W);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - WIN_H);
  localparam logic [AW-1:0] NLAST = AW'(N - 1);
  localparam logic [CW-1:0] WW1  = CW'(WIN_W - 1);
  localparam logic [CW-1:0] WH1  = CW'(WIN_H - 1);

  localparam logic [3:0] CMD_LOAD  = 4'd0;
  localparam logic [3:0] CMD_ROT_L = 4'd1;
  localparam logic [3:0] CMD_ROT_R = 4'd2;
  localparam logic [3:0] CMD_ZIN   = 4'd3;
  localparam logic [3:0] CMD_ZFIT  = 4'd4;
  localparam logic [3:0] CMD_SH_R  = 4'd5;
  localparam logic [3:0] CMD_SH_L  = 4'd6;
  localparam logic [3:0] CMD_SH_U  = 4'd7;
  localparam logic [3:0] CMD_SH_D  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT} state_t;

  // Everything that determines which pixels make up the view.
  typedef struct packed {
    logic          zoom;    // 1 = 1:1 window, 0 = fit
    logic [1:0]    orient;  // quarter turns clockwise
    logic [XW-1:0] x;       // window origin, frame coordinates
    logic [YW-1:0] y;
  } view_t;

  state_t            state, state_nxt;
  view_t             view, view_nxt;
  logic [AW-1:0]     ld_cnt;
  logic [CW-1:0]     outer, inner, outer_nxt, inner_nxt;
  logic              accept, last_pix, start_out;
  view_t             rd_view;
  logic [CW-1:0]     rd_outer, rd_inner;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [N];

  // Map a scan position (outer/inner loop indices) to a frame buffer address.
  // Orients 0/2 scan rows outer, 1/3 scan columns outer.
  function automatic logic [AW-1:0] pix_addr(input view_t v, input logic [CW-1:0] o,
                                             input logic [CW-1:0] i);
    int c, r, row, col;
    case (v.orient)
      2'd0:    begin r = int'(o);             c = int'(i);             end
      2'd1:    begin c = int'(o);             r = WIN_H - 1 - int'(i); end
      2'd2:    begin r = WIN_H - 1 - int'(o); c = WIN_W - 1 - int'(i); end
      default: begin c = WIN_W - 1 - int'(o); r = int'(i);             end
    endcase
    if (v.zoom) begin
      row = int'(v.y) + r;
      col = int'(v.x) + c;
    end else begin
      row = r * SY + SY / 2;
      col = c * SX + SX / 2;
    end
    return AW'(row * IMG_W + col);
  endfunction

  assign busy     = (state != S_IDLE);
  assign accept   = (state == S_IDLE) && cmd_valid;
  assign last_pix = (inner == (view.orient[0] ? WH1 : WW1)) &&
                    (outer == (view.orient[0] ? WW1 : WH1));
  // First pixel is fetched in the accept cycle (or the last load cycle) so
  // the registered output is valid on the very next cycle.
  assign start_out = (accept && cmd != CMD_LOAD) ||
                     (state == S_LOAD && ld_cnt == NLAST);

  // Command decode: view state as it will be after this command.
  always_comb begin
    view_nxt = view;
    case (cmd)
      CMD_LOAD:  view_nxt = '{zoom: 1'b0, orient: 2'd0, x: X0, y: Y0};
      CMD_ROT_L: view_nxt.orient = view.orient - 2'd1;
      CMD_ROT_R: view_nxt.orient = view.orient + 2'd1;
      CMD_ZIN: begin
        view_nxt.zoom = 1'b1;
        if (!view.zoom) begin
          view_nxt.x = X0;
          view_nxt.y = Y0;
        end
      end
      CMD_ZFIT: begin
        view_nxt.zoom = 1'b0;
        view_nxt.x    = X0;
        view_nxt.y    = Y0;
      end
      CMD_SH_R: if (view.zoom && view.x < XMAX) view_nxt.x = view.x + 1'b1;
      CMD_SH_L: if (view.zoom && view.x != '0)  view_nxt.x = view.x - 1'b1;
      CMD_SH_U: if (view.zoom && view.y != '0)  view_nxt.y = view.y - 1'b1;
      CMD_SH_D: if (view.zoom && view.y < YMAX) view_nxt.y = view.y + 1'b1;
      default: ;
    endcase
  end

  // Scan counter advance: inner loop runs fastest, then outer.
  always_comb begin
    inner_nxt = inner + 1'b1;
    outer_nxt = outer;
    if (inner == (view.orient[0] ? WH1 : WW1)) begin
      inner_nxt = '0;
      outer_nxt = outer + 1'b1;
    end
  end

  // Select which pixel to fetch next and read it, forwarding the pixel being written.
  always_comb begin
    rd_view  = view;
    rd_outer = outer_nxt;
    rd_inner = inner_nxt;
    if (start_out) begin
      rd_view  = accept ? view_nxt : view;
      rd_outer = '0;
      rd_inner = '0;
    end
    rd_addr = pix_addr(rd_view, rd_outer, rd_inner);
    rd_data = (state == S_LOAD && ld_cnt == rd_addr) ? datain : mem[rd_addr];
  end

  // Next-state logic for IDLE -> LOAD/OUT -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = (cmd == CMD_LOAD) ? S_LOAD : S_OUT;
      S_LOAD:  if (ld_cnt == NLAST) state_nxt = S_OUT;
      S_OUT:   if (last_pix) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // View registers, load/scan counters and the registered pixel output.
  always_ff @(posedge clk) begin
    if (reset) begin
      view         <= '{zoom: 1'b0, orient: 2'd0, x: X0, y: Y0};
      ld_cnt       <= '0;
      outer        <= '0;
      inner        <= '0;
      dataout      <= '0;
      output_valid <= 1'b0;
    end else begin
      if (accept) begin
        view   <= view_nxt;
        ld_cnt <= '0;
      end
      if (state == S_LOAD) ld_cnt <= ld_cnt + 1'b1;
      if (start_out) begin
        dataout      <= rd_data;
        output_valid <= 1'b1;
        outer        <= '0;
        inner        <= '0;
      end else if (state == S_OUT) begin
        if (last_pix) begin
          output_valid <= 1'b0;
        end else begin
          dataout <= rd_data;
          outer   <= outer_nxt;
          inner   <= inner_nxt;
        end
      end
    end
  end

  // Frame buffer write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && !reset) mem[ld_cnt] <= datain;
  end

endmodule
